// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues I-cache reads and loads the IF/ID register (FETCH_PERF_EN adds perf counters).
// Latency: an instruction reaches IF/ID on the edge its imem_resp is seen; a 1-cycle hit sustains 1 instr/cycle.
// Backpressure: load_if_id=0 parks a returned word in a one-entry hold buffer and drops imem_read until released.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h4000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_if_id,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_ir,
    output logic        if_id_valid,
    output logic        if_busy,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
);

    typedef enum logic [1:0] {
        REQ  = 2'b00,
        HOLD = 2'b01,
        DROP = 2'b10
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic [31:0] hold_pc, hold_pc_nxt;
    logic [31:0] hold_ir, hold_ir_nxt;
    logic [31:0] if_id_pc_nxt, if_id_ir_nxt;
    logic        if_id_valid_nxt;
    logic        resp_mask;
    logic        resp_ok;
    logic        deliver;
    logic [31:0] dlv_pc, dlv_ir;

    // A response in the first cycle out of reset belongs to a pre-reset request.
    assign resp_ok = imem_resp & ~resp_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= REQ;
            pc          <= RESET_PC;
            pend_pc     <= '0;
            hold_pc     <= '0;
            hold_ir     <= '0;
            if_id_pc    <= '0;
            if_id_ir    <= NOP_INSTR;
            if_id_valid <= 1'b0;
            resp_mask   <= 1'b1;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_pc     <= pend_pc_nxt;
            hold_pc     <= hold_pc_nxt;
            hold_ir     <= hold_ir_nxt;
            if_id_pc    <= if_id_pc_nxt;
            if_id_ir    <= if_id_ir_nxt;
            if_id_valid <= if_id_valid_nxt;
            resp_mask   <= 1'b0;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pend_pc_nxt = pend_pc;
        hold_pc_nxt = hold_pc;
        hold_ir_nxt = hold_ir;
        deliver     = 1'b0;
        dlv_pc      = pc;
        dlv_ir      = imem_rdata;

        case (state)
            REQ: begin
                if (redirect_valid) begin
                    if (resp_ok) begin
                        pc_nxt = redirect_pc;
                    end else begin
                        // The outstanding read must complete at the old address first.
                        pend_pc_nxt = redirect_pc;
                        state_nxt   = DROP;
                    end
                end else if (resp_ok) begin
                    if (load_if_id) begin
                        deliver = 1'b1;
                        pc_nxt  = pc + 32'd4;
                    end else begin
                        hold_pc_nxt = pc;
                        hold_ir_nxt = imem_rdata;
                        state_nxt   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = REQ;
                end else if (load_if_id) begin
                    deliver   = 1'b1;
                    dlv_pc    = hold_pc;
                    dlv_ir    = hold_ir;
                    pc_nxt    = pc + 32'd4;
                    state_nxt = REQ;
                end
            end
            DROP: begin
                if (resp_ok) begin
                    pc_nxt    = redirect_valid ? redirect_pc : pend_pc;
                    state_nxt = REQ;
                end else if (redirect_valid) begin
                    pend_pc_nxt = redirect_pc;
                end
            end
            default: begin
                pc_nxt    = RESET_PC;
                state_nxt = REQ;
            end
        endcase
    end

    always_comb begin
        if_id_pc_nxt    = if_id_pc;
        if_id_ir_nxt    = if_id_ir;
        if_id_valid_nxt = if_id_valid;
        if (redirect_valid) begin
            if_id_ir_nxt    = NOP_INSTR;
            if_id_valid_nxt = 1'b0;
        end else if (load_if_id) begin
            if (deliver) begin
                if_id_pc_nxt    = dlv_pc;
                if_id_ir_nxt    = dlv_ir;
                if_id_valid_nxt = 1'b1;
            end else begin
                if_id_ir_nxt    = NOP_INSTR;
                if_id_valid_nxt = 1'b0;
            end
        end
    end

    assign imem_address = pc;
    assign imem_read    = (state != HOLD);
    assign if_busy      = ((state == REQ) && !resp_ok) || (state == DROP);

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (deliver) fetched_q <= fetched_q + 32'd1;
            if (if_busy) stall_q   <= stall_q + 32'd1;
        end
    end

    assign perf_fetched      = fetched_q;
    assign perf_stall_cycles = stall_q;
`else
    assign perf_fetched      = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule
